// File: rtl/chrom_eval_pkg.sv
// Shared types and constants for the chromosome evaluation controller.
package chrom_eval_pkg;

  localparam int SEG_W    = 32;
  localparam int NUM_SUMS = 8;

  // error_sum slots above the per-output counters
  localparam int TOTAL  = 5;
  localparam int STEPS  = 6;
  localparam int CYCLES = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE,
    ST_WAIT_REL
  } state_e;

endpackage

// File: rtl/chrom_eval_if.sv
// HPS PIO bundle between the HPS bridge (master) and the evaluation controller (slave).
interface chrom_eval_if
  import chrom_eval_pkg::*;
#(
  parameter int NUM_SEGS = 31,
  parameter int NUM_IO   = 5
);

  logic [NUM_SEGS*SEG_W-1:0] chrom_seg;
  logic [NUM_IO*SEG_W-1:0]   input_sequence;
  logic [NUM_IO*SEG_W-1:0]   expected_output;
  logic [NUM_IO*SEG_W-1:0]   valid_output;
  logic [SEG_W-1:0]          sequences_to_process;
  logic                      start_processing_chrom;
  logic                      done_processing_feedback;
  logic                      ready_to_process;
  logic                      done_processing_chrom;
  logic [NUM_SUMS*SEG_W-1:0] error_sum;

  modport master (
    output chrom_seg, input_sequence, expected_output, valid_output,
           sequences_to_process, start_processing_chrom, done_processing_feedback,
    input  ready_to_process, done_processing_chrom, error_sum
  );

  modport slave (
    input  chrom_seg, input_sequence, expected_output, valid_output,
           sequences_to_process, start_processing_chrom, done_processing_feedback,
    output ready_to_process, done_processing_chrom, error_sum
  );

endinterface

// File: rtl/chrom_eval_cmp.sv
// Combinational compare of one test step: masked mismatch vector and its popcount.
module chrom_eval_cmp #(
  parameter int NUM_IO = 5,
  parameter int CNT_W  = $clog2(NUM_IO + 1)
) (
  input  logic [NUM_IO-1:0] circ_out,
  input  logic [NUM_IO-1:0] exp_bits,
  input  logic [NUM_IO-1:0] val_bits,
  output logic [NUM_IO-1:0] mism,
  output logic [CNT_W-1:0]  mism_cnt
);

  always_comb begin
    mism     = (circ_out ^ exp_bits) & val_bits;
    mism_cnt = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      mism_cnt = mism_cnt + CNT_W'(mism[k]);
    end
  end

endmodule

// File: rtl/chrom_eval_ctrl.sv
// Evaluation controller: latches a chromosome and test vectors, steps the circuit and counts errors.
// Optional macro CHROM_EVAL_PER_OUTPUT_EN builds the per-output counters in error_sum_0..4.
module chrom_eval_ctrl
  import chrom_eval_pkg::*;
#(
  parameter int NUM_SEGS      = 31,
  parameter int NUM_IO        = 5,
  parameter int MAX_STEPS     = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  chrom_eval_if.slave               pio,
  output logic [NUM_SEGS*SEG_W-1:0] chrom_cfg,
  output logic [NUM_IO-1:0]         circ_in,
  input  logic [NUM_IO-1:0]         circ_out
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam int IDX_W  = $clog2(MAX_STEPS);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W  = $clog2(NUM_IO + 1);

  state_e                            state_q, state_d;
  logic [STEP_W-1:0]                 step_q, step_d;
  logic [STEP_W-1:0]                 n_q, n_d;
  logic [SET_W-1:0]                  settle_q, settle_d;
  logic [NUM_SEGS*SEG_W-1:0]         cfg_q, cfg_d;
  logic [NUM_IO-1:0]                 circ_in_q, circ_in_d;
  logic [NUM_IO-1:0][SEG_W-1:0]      seq_q, seq_d;
  logic [NUM_IO-1:0][SEG_W-1:0]      exp_q, exp_d;
  logic [NUM_IO-1:0][SEG_W-1:0]      val_q, val_d;
  logic [NUM_SUMS-1:0][SEG_W-1:0]    sum_q, sum_d;

  logic [IDX_W-1:0]  step_idx;
  logic [NUM_IO-1:0] exp_bits, val_bits, mism;
  logic [CNT_W-1:0]  mism_cnt;

  assign step_idx = step_q[IDX_W-1:0];

  always_comb begin
    for (int k = 0; k < NUM_IO; k++) begin
      exp_bits[k] = exp_q[k][step_idx];
      val_bits[k] = val_q[k][step_idx];
    end
  end

  chrom_eval_cmp #(
    .NUM_IO (NUM_IO),
    .CNT_W  (CNT_W)
  ) u_cmp (
    .circ_out (circ_out),
    .exp_bits (exp_bits),
    .val_bits (val_bits),
    .mism     (mism),
    .mism_cnt (mism_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      n_q       <= '0;
      settle_q  <= '0;
      cfg_q     <= '0;
      circ_in_q <= '0;
      seq_q     <= '0;
      exp_q     <= '0;
      val_q     <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      n_q       <= n_d;
      settle_q  <= settle_d;
      cfg_q     <= cfg_d;
      circ_in_q <= circ_in_d;
      seq_q     <= seq_d;
      exp_q     <= exp_d;
      val_q     <= val_d;
      sum_q     <= sum_d;
    end
  end

  // The cycle slot starts at 1 in LOAD and counts every APPLY/SETTLE/SAMPLE cycle.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    n_d       = n_q;
    settle_d  = settle_q;
    cfg_d     = cfg_q;
    circ_in_d = circ_in_q;
    seq_d     = seq_q;
    exp_d     = exp_q;
    val_d     = val_q;
    sum_d     = sum_q;

    case (state_q)
      ST_IDLE: begin
        if (pio.start_processing_chrom) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        cfg_d     = pio.chrom_seg;
        seq_d     = pio.input_sequence;
        exp_d     = pio.expected_output;
        val_d     = pio.valid_output;
        n_d       = (pio.sequences_to_process > SEG_W'(MAX_STEPS)) ?
                    STEP_W'(MAX_STEPS) : pio.sequences_to_process[STEP_W-1:0];
        step_d    = '0;
        circ_in_d = '0;
        sum_d     = '0;
        sum_d[CYCLES] = SEG_W'(1);
        state_d   = (n_d == '0) ? ST_DONE : ST_APPLY;
      end

      ST_APPLY: begin
        for (int k = 0; k < NUM_IO; k++) begin
          circ_in_d[k] = seq_q[k][step_idx];
        end
        settle_d      = SET_W'(SETTLE_CYCLES);
        sum_d[CYCLES] = sum_q[CYCLES] + SEG_W'(1);
        state_d       = ST_SETTLE;
      end

      ST_SETTLE: begin
        settle_d      = settle_q - SET_W'(1);
        sum_d[CYCLES] = sum_q[CYCLES] + SEG_W'(1);
        if (settle_q == SET_W'(1)) state_d = ST_SAMPLE;
      end

      ST_SAMPLE: begin
        sum_d[CYCLES] = sum_q[CYCLES] + SEG_W'(1);
`ifdef CHROM_EVAL_PER_OUTPUT_EN
        for (int k = 0; k < NUM_IO; k++) begin
          sum_d[k] = sum_q[k] + SEG_W'(mism[k]);
        end
`endif
        if (|mism) sum_d[TOTAL] = sum_q[TOTAL] + SEG_W'(mism_cnt);
        sum_d[STEPS] = SEG_W'(step_q) + SEG_W'(1);
        step_d       = step_q + STEP_W'(1);
        if (step_d == n_q) begin
          circ_in_d = '0;
          state_d   = ST_DONE;
        end else begin
          state_d   = ST_APPLY;
        end
      end

      ST_DONE: begin
        if (pio.done_processing_feedback) state_d = ST_WAIT_REL;
      end

      // A held start cannot retrigger until both HPS levels have dropped.
      ST_WAIT_REL: begin
        if (!pio.done_processing_feedback && !pio.start_processing_chrom) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign pio.ready_to_process      = (state_q == ST_IDLE);
  assign pio.done_processing_chrom = (state_q == ST_DONE);
  assign pio.error_sum             = sum_q;
  assign chrom_cfg                 = cfg_q;
  assign circ_in                   = circ_in_q;

endmodule

// File: tb/tb_chrom_eval_ctrl.sv
// Self-checking bench for chrom_eval_ctrl with a loopback circuit and a behavioural error model.
module tb_chrom_eval_ctrl;
  import chrom_eval_pkg::*;

  localparam int NSEG   = 31;
  localparam int NIO    = 5;
  localparam int MAXS   = 32;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chrom_eval_if #(.NUM_SEGS(NSEG), .NUM_IO(NIO)) pio();

  logic [NSEG*32-1:0] chrom_cfg;
  logic [NIO-1:0]     circ_in, circ_out, resp_mask;

  // Evolved circuit stand-in: wire-through with optional per-output inversion.
  assign circ_out = circ_in ^ resp_mask;

  chrom_eval_ctrl #(
    .NUM_SEGS      (NSEG),
    .NUM_IO        (NIO),
    .MAX_STEPS     (MAXS),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pio       (pio),
    .chrom_cfg (chrom_cfg),
    .circ_in   (circ_in),
    .circ_out  (circ_out)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]        m_in[NIO], m_exp[NIO], m_val[NIO];
  logic [31:0]        m_req;
  logic [NSEG*32-1:0] m_chrom;
  logic [31:0]        exp_sum[8];

  task automatic drive_pio();
    for (int k = 0; k < NIO; k++) begin
      pio.input_sequence[k*32 +: 32]  = m_in[k];
      pio.expected_output[k*32 +: 32] = m_exp[k];
      pio.valid_output[k*32 +: 32]    = m_val[k];
    end
    pio.sequences_to_process = m_req;
    pio.chrom_seg            = m_chrom;
  endtask

  task automatic random_model(input logic [31:0] req);
    for (int k = 0; k < NIO; k++) begin
      m_in[k]  = $urandom;
      m_exp[k] = $urandom;
      m_val[k] = $urandom;
    end
    for (int s = 0; s < NSEG; s++) m_chrom[s*32 +: 32] = $urandom;
    m_req = req;
  endtask

  task automatic scramble_pio();
    for (int s = 0; s < NSEG; s++) pio.chrom_seg[s*32 +: 32] = $urandom;
    for (int k = 0; k < NIO; k++) begin
      pio.input_sequence[k*32 +: 32]  = $urandom;
      pio.expected_output[k*32 +: 32] = $urandom;
      pio.valid_output[k*32 +: 32]    = $urandom;
    end
    pio.sequences_to_process = $urandom_range(0, 40);
  endtask

  // Expected sums straight from the step rules: clamp N, walk every step and output.
  task automatic model_eval();
    int n;
    n = (m_req > 32'(MAXS)) ? MAXS : int'(m_req);
    for (int i = 0; i < 8; i++) exp_sum[i] = 0;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < NIO; k++) begin
        if (((m_in[k][s] ^ resp_mask[k]) ^ m_exp[k][s]) & m_val[k][s]) begin
`ifdef CHROM_EVAL_PER_OUTPUT_EN
          exp_sum[k] = exp_sum[k] + 1;
`endif
          exp_sum[5] = exp_sum[5] + 1;
        end
      end
    end
    exp_sum[6] = n;
    exp_sum[7] = 1 + n * (SETTLE + 2);
  endtask

  task automatic run_to_done(input bit scramble, output bit ok);
    drive_pio();
    @(negedge clk);
    pio.start_processing_chrom = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (scramble) scramble_pio();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (pio.done_processing_chrom === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic release_handshake();
    pio.done_processing_feedback = 1'b1;
    @(negedge clk);
    pio.start_processing_chrom   = 1'b0;
    pio.done_processing_feedback = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (pio.ready_to_process !== 1'b1 || pio.done_processing_chrom !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hs ready=%b done=%b required ready=1 done=0",
               pio.ready_to_process, pio.done_processing_chrom);
    end
    checks++;
    if (pio.error_sum !== '0 || chrom_cfg !== '0 || circ_in !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs error_sum=%h cfg_nonzero=%b circ_in=%b required all zero",
               pio.error_sum, |chrom_cfg, circ_in);
    end
  endtask

  task automatic test_loopback(input string name, input bit invert, input logic [31:0] valid);
    bit ok;
    random_model(4);
    for (int k = 0; k < NIO; k++) begin
      m_exp[k] = invert ? ~m_in[k] : m_in[k];
      m_val[k] = valid;
    end
    resp_mask = '0;
    model_eval();
    run_to_done(1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s_timeout done=0 required done=1", name);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pio.error_sum[i*32 +: 32] !== exp_sum[i]) begin
        errors++;
        $display("[TB] FAIL %s_sum%0d got=%0d required=%0d", name, i, pio.error_sum[i*32 +: 32], exp_sum[i]);
      end
    end
    checks++;
    if (chrom_cfg !== m_chrom || circ_in !== '0) begin
      errors++;
      $display("[TB] FAIL %s_cfg cfg_match=%b circ_in=%b required match=1 circ_in=0",
               name, chrom_cfg === m_chrom, circ_in);
    end
    release_handshake();
  endtask

  task automatic test_step_bounds();
    bit ok;
    logic [31:0] reqs[2];
    reqs[0] = 0;
    reqs[1] = 40;
    for (int r = 0; r < 2; r++) begin
      random_model(reqs[r]);
      resp_mask = NIO'($urandom);
      model_eval();
      run_to_done(1'b0, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL bounds_timeout req=%0d done=0 required done=1", reqs[r]);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (pio.error_sum[i*32 +: 32] !== exp_sum[i]) begin
          errors++;
          $display("[TB] FAIL bounds_req%0d_sum%0d got=%0d required=%0d",
                   reqs[r], i, pio.error_sum[i*32 +: 32], exp_sum[i]);
        end
      end
      release_handshake();
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 8; it++) begin
      random_model($urandom_range(0, 40));
      resp_mask = NIO'($urandom);
      model_eval();
      run_to_done(1'b1, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL random%0d_timeout done=0 required done=1", it);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (pio.error_sum[i*32 +: 32] !== exp_sum[i]) begin
          errors++;
          $display("[TB] FAIL random%0d_sum%0d req=%0d got=%0d required=%0d",
                   it, i, m_req, pio.error_sum[i*32 +: 32], exp_sum[i]);
        end
      end
      checks++;
      if (chrom_cfg !== m_chrom) begin
        errors++;
        $display("[TB] FAIL random%0d_cfg latched chromosome changed after LOAD", it);
      end
      release_handshake();
    end
  endtask

  task automatic test_handshake();
    bit ok;
    random_model($urandom_range(1, 6));
    resp_mask = '0;
    run_to_done(1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL hs_timeout done=0 required done=1");
    end
    repeat (2) @(negedge clk);
    checks++;
    if (pio.done_processing_chrom !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hs_done_hold done=%b required 1", pio.done_processing_chrom);
    end
    pio.done_processing_feedback = 1'b1;
    @(negedge clk);
    checks++;
    if (pio.done_processing_chrom !== 1'b0 || pio.ready_to_process !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hs_done_fall done=%b ready=%b required done=0 ready=0",
               pio.done_processing_chrom, pio.ready_to_process);
    end
    repeat (3) @(negedge clk);
    pio.done_processing_feedback = 1'b0;
    @(negedge clk);
    checks++;
    if (pio.ready_to_process !== 1'b0 || pio.done_processing_chrom !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hs_start_held ready=%b done=%b required ready=0 done=0",
               pio.ready_to_process, pio.done_processing_chrom);
    end
    pio.start_processing_chrom = 1'b0;
    @(negedge clk);
    checks++;
    if (pio.ready_to_process !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hs_ready ready=%b required 1", pio.ready_to_process);
    end
    @(negedge clk);
    checks++;
    if (pio.ready_to_process !== 1'b1 || chrom_cfg !== m_chrom || circ_in !== '0) begin
      errors++;
      $display("[TB] FAIL hs_idle_hold ready=%b cfg_match=%b circ_in=%b required ready=1 match=1 circ_in=0",
               pio.ready_to_process, chrom_cfg === m_chrom, circ_in);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    logic [NIO-1:0] exp_in;
    random_model(4);
    resp_mask = '0;
    drive_pio();
    @(negedge clk);
    pio.start_processing_chrom = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 0; k < NIO; k++) exp_in[k] = m_in[k][1];
    checks++;
    if (circ_in !== exp_in) begin
      errors++;
      $display("[TB] FAIL mid_step2_stim circ_in=%b required=%b", circ_in, exp_in);
    end
    reset = 1'b1;
    pio.start_processing_chrom = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (pio.ready_to_process !== 1'b1 || pio.done_processing_chrom !== 1'b0 ||
        pio.error_sum !== '0 || chrom_cfg !== '0 || circ_in !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset ready=%b done=%b error_sum=%h cfg_nonzero=%b circ_in=%b required idle and zero",
               pio.ready_to_process, pio.done_processing_chrom, pio.error_sum, |chrom_cfg, circ_in);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (pio.done_processing_chrom === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || pio.ready_to_process !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_no_done saw_done=%b ready=%b required saw_done=0 ready=1",
               saw_done, pio.ready_to_process);
    end
  endtask

  initial begin
    reset                        = 1'b1;
    resp_mask                    = '0;
    pio.start_processing_chrom   = 1'b0;
    pio.done_processing_feedback = 1'b0;
    pio.chrom_seg                = '0;
    pio.input_sequence           = '0;
    pio.expected_output          = '0;
    pio.valid_output             = '0;
    pio.sequences_to_process     = '0;

    test_reset();
    test_loopback("match", 1'b0, 32'hFFFF_FFFF);
    test_loopback("invert", 1'b1, 32'h0000_0003);
    test_step_bounds();
    test_random();
    test_handshake();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
